boot_imem: RTL and testbench

Parametrised, boot-loadable instruction memory for the processor fetch stage. It supersedes a fixed case-table instruction ROM with a writable word array that is filled at boot through a valid/ready load stream. After boot it serves fetches with a registered address, stall hold, NOP masking of unloaded or out-of-range words, and a reload path back to boot mode.

---
 rtl/imem_pkg.sv | 11 +
 rtl/boot_imem_if.sv | 29 ++
 rtl/imem_array.sv | 25 ++
 rtl/boot_imem.sv | 100 ++++++++++
 tb/tb_boot_imem.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loadable instruction memory.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/boot_imem_if.sv
// Fetch, control and boot-load signal bundle for boot_imem.
interface boot_imem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int DEPTH  = 1024
);

  logic [ADDR_W-1:0]        addr;
  logic                     stall;
  logic                     reload;
  logic                     ld_valid;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     running;
  logic [DATA_W-1:0]        inst;
  logic [$clog2(DEPTH):0]   nwords;

  modport master (
    output addr, stall, reload, ld_valid, ld_data, ld_last,
    input  ld_ready, running, inst, nwords
  );

  modport slave (
    input  addr, stall, reload, ld_valid, ld_data, ld_last,
    output ld_ready, running, inst, nwords
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W word array: one synchronous write port, one combinational read port.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  // Contents are never reset; stale words are hidden by the word count in the top.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/boot_imem.sv
// Boot-loadable instruction memory: load stream fills the array in BOOT, fetch serves it in RUN.
module boot_imem
  import imem_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 30,
  parameter int                 DEPTH  = 1024,
  parameter logic [DATA_W-1:0]  NOP    = DATA_W'(IMEM_NOP)
) (
  input  logic       clk,
  input  logic       rst,
  boot_imem_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NW_W  = AW + 1;
  localparam int CMP_W = (ADDR_W > NW_W) ? ADDR_W : NW_W;

  imem_state_t       r_state;
  imem_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [AW-1:0]     r_wptr;
  logic [NW_W-1:0]   r_nwords;
  logic              w_accept;
  logic              w_final;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The last slot always ends boot, so nwords can never pass DEPTH.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      BOOT: begin
        w_accept = bus.ld_valid;
        w_final  = w_accept & (bus.ld_last | (r_wptr == AW'(DEPTH - 1)));
        if (w_final) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.reload) begin
          w_state_nxt = BOOT;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_nwords <= '0;
    end else if ((r_state == RUN) && bus.reload) begin
      r_wptr   <= '0;
      r_nwords <= '0;
    end else if (w_accept) begin
      r_wptr   <= r_wptr + AW'(1);
      r_nwords <= r_nwords + NW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (!bus.stall) begin
      r_addr <= bus.addr;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wptr),
    .wdata (bus.ld_data),
    .raddr (r_addr[AW-1:0]),
    .rdata (w_rdata)
  );

  // Full-width compare so high address bits cannot alias into the array.
  assign w_in_range = CMP_W'(r_addr) < CMP_W'(r_nwords);

  assign bus.inst     = ((r_state == RUN) && w_in_range) ? w_rdata : NOP;
  assign bus.ld_ready = (r_state == BOOT);
  assign bus.running  = (r_state == RUN);
  assign bus.nwords   = r_nwords;

endmodule

// File: tb/tb_boot_imem.sv
// Scoreboard bench for boot_imem with an 8-word array.
module tb_boot_imem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;
  localparam int DEPTH  = 8;

  localparam logic [31:0] W1 [3] = '{32'h24170000, 32'h24100020, 32'h24080020};
  localparam logic [31:0] WT [5] = '{32'h11110001, 32'h22220002, 32'h33330003,
                                     32'h44440004, 32'h55550005};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boot_imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  boot_imem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NOP    (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_n;
  bit m_run;
  logic [31:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr     = '0;
    bus.stall    = 1'b0;
    bus.reload   = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_n = 0;
    m_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    if (!m_run) begin
      m_n++;
      if (last || m_n == DEPTH) m_run = 1'b1;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.addr = 30'h5;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready: got %b expected 1", bus.ld_ready); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b expected 0", bus.running); end
    checks++; if (bus.nwords !== 4'd0) begin errors++; $display("FAIL rst_nwords: got %0d expected 0", bus.nwords); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 00000000", bus.inst); end
    rst = 1'b0;
    bus.addr = '0;
    m_n = 0;
    m_run = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [ADDR_W-1:0] a [5] = '{30'd0, 30'd1, 30'd2, 30'd3, 30'h3FFFFFFF};
    logic [31:0] e [5];
    logic [31:0] got, exp;
    e = '{W1[0], W1[1], W1[2], 32'h0, 32'h0};
    do_reset();
    load_word(W1[0], 1'b0);
    load_word(W1[1], 1'b0);
    checks++; if (bus.running !== 1'b0 || bus.ld_ready !== 1'b1) begin errors++; $display("FAIL basic_midload: got running=%b ready=%b expected 0/1", bus.running, bus.ld_ready); end
    load_word(W1[2], 1'b1);
    checks++; if (bus.running !== 1'b1 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL basic_done: got running=%b ready=%b expected 1/0", bus.running, bus.ld_ready); end
    checks++; if (bus.nwords !== 4'd3) begin errors++; $display("FAIL basic_nwords: got %0d expected 3", bus.nwords); end
    checks++; if (bus.inst !== W1[0]) begin errors++; $display("FAIL basic_word0_now: got %h expected %h", bus.inst, W1[0]); end
    bus.ld_valid = 1'b1; bus.ld_data = 32'hDEADBEEF; bus.ld_last = 1'b0;
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.nwords !== 4'd3) begin errors++; $display("FAIL basic_run_ignore: got %0d expected 3", bus.nwords); end
    for (int k = 0; k < 5; k++) begin
      bus.addr = a[k];
      exp_q.push_back(e[k]);
      tick();
      got = bus.inst;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL basic_fetch%0d: got %h expected %h", k, got, exp); end
    end
  endtask

  task automatic test_toggle();
    logic [31:0] got, exp;
    int k = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) begin
        bus.ld_valid = 1'b1; bus.ld_data = WT[k]; bus.ld_last = (k == 4);
        k++;
        m_n++;
        if (k == 5) m_run = 1'b1;
      end else begin
        bus.ld_valid = 1'b0; bus.ld_data = 32'hBAD00000 | c; bus.ld_last = 1'b1;
      end
      tick();
      checks++; if (bus.nwords !== 4'(m_n)) begin errors++; $display("FAIL toggle_nwords_c%0d: got %0d expected %0d", c, bus.nwords, m_n); end
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.addr = 30'(i);
      exp_q.push_back(i < 5 ? WT[i] : 32'h0);
      tick();
      got = bus.inst;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL toggle_fetch%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got, exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 32'hA0000000 + i; bus.ld_last = 1'b0;
      tick();
      if (!m_run) begin
        m_n++;
        if (m_n == DEPTH) m_run = 1'b1;
      end
      checks++; if (bus.ld_ready !== !m_run) begin errors++; $display("FAIL ovf_ready_w%0d: got %b expected %b", i, bus.ld_ready, !m_run); end
    end
    bus.ld_valid = 1'b0;
    checks++; if (bus.nwords !== 4'd8) begin errors++; $display("FAIL ovf_nwords: got %0d expected 8", bus.nwords); end
    for (int i = 0; i < 9; i++) begin
      bus.addr = 30'(i);
      exp_q.push_back(i < 8 ? 32'hA0000000 + i : 32'h0);
      tick();
      got = bus.inst;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL ovf_fetch%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_stall();
    bus.addr = 30'd1; bus.stall = 1'b0;
    tick();
    checks++; if (bus.inst !== 32'hA0000001) begin errors++; $display("FAIL stall_pre: got %h expected a0000001", bus.inst); end
    bus.addr = 30'd2; bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.inst !== 32'hA0000001) begin errors++; $display("FAIL stall_hold%0d: got %h expected a0000001", c, bus.inst); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.inst !== 32'hA0000002) begin errors++; $display("FAIL stall_release: got %h expected a0000002", bus.inst); end
    // reload and stall together: leave RUN while addr_r stays at 2
    bus.addr = 30'd5; bus.stall = 1'b1; bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    m_n = 0; m_run = 1'b0;
    checks++; if (bus.running !== 1'b0 || bus.inst !== 32'h0) begin errors++; $display("FAIL stall_reload: got running=%b inst=%h expected 0/00000000", bus.running, bus.inst); end
    for (int i = 0; i < 4; i++) load_word(32'hC0000000 + i, i == 3);
    checks++; if (bus.inst !== 32'hC0000002) begin errors++; $display("FAIL stall_reload_hold: got %h expected c0000002", bus.inst); end
    bus.stall = 1'b0;
  endtask

  task automatic test_reload();
    logic [31:0] got, exp;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    m_n = 0; m_run = 1'b0;
    checks++; if (bus.running !== 1'b0 || bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reload_state: got running=%b ready=%b expected 0/1", bus.running, bus.ld_ready); end
    checks++; if (bus.nwords !== 4'd0) begin errors++; $display("FAIL reload_nwords: got %0d expected 0", bus.nwords); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reload_inst: got %h expected 00000000", bus.inst); end
    bus.reload = 1'b1;
    load_word(32'h26f70001, 1'b1);
    bus.reload = 1'b0;
    checks++; if (bus.running !== 1'b1 || bus.nwords !== 4'd1) begin errors++; $display("FAIL reload_boot_ignored: got running=%b nwords=%0d expected 1/1", bus.running, bus.nwords); end
    for (int i = 0; i < 2; i++) begin
      bus.addr = 30'(i);
      exp_q.push_back(i == 0 ? 32'h26f70001 : 32'h0);
      tick();
      got = bus.inst;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL reload_fetch%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_rst_midload();
    logic [31:0] got, exp;
    do_reset();
    load_word(32'h77770000, 1'b0);
    load_word(32'h77770001, 1'b0);
    bus.addr = 30'd2; bus.stall = 1'b1; bus.reload = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_data = 32'h77770002; bus.ld_last = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.stall = 1'b1;
    m_n = 0; m_run = 1'b0;
    checks++; if (bus.ld_ready !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL midrst_state: got ready=%b running=%b expected 1/0", bus.ld_ready, bus.running); end
    checks++; if (bus.nwords !== 4'd0 || bus.inst !== 32'h0) begin errors++; $display("FAIL midrst_outputs: got nwords=%0d inst=%h expected 0/00000000", bus.nwords, bus.inst); end
    for (int i = 0; i < 3; i++) load_word(W1[i], i == 2);
    checks++; if (bus.nwords !== 4'd3 || bus.running !== 1'b1) begin errors++; $display("FAIL midrst_reload: got nwords=%0d running=%b expected 3/1", bus.nwords, bus.running); end
    checks++; if (bus.inst !== W1[0]) begin errors++; $display("FAIL midrst_addr0: got %h expected %h", bus.inst, W1[0]); end
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addr = 30'(i);
      exp_q.push_back(i < 3 ? W1[i] : 32'h0);
      tick();
      got = bus.inst;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL midrst_fetch%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_basic();
    test_toggle();
    test_overflow();
    test_stall();
    test_reload();
    test_rst_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
